simeck_key_sched: RTL
=====================

Name: simeck_key_sched

Overview:
- Round-key generator and sequencer for the Simeck32/64 decrypt datapath.
- Captures a 64-bit master key and expands it into ROUNDS 16-bit round keys, held in an internal buffer.
- Then drives the decrypt stage: a 2-cycle load strobe (dctr), followed by one round key per cycle on its key input (C), in reverse order for decryption.
- Sits directly upstream of the decrypt stage, feeding its C and dctr inputs.

Parameters:
- DATAW, 16, word width; the key is 4*DATAW.
- ROUNDS, 32, number of round keys generated and played back.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- key_in  input  4*DATAW  master key {k3,k2,k1,k0}; k0 in the LSBs. Sampled only on an accepted start.
- start  input  1  request pulse; accepted only in IDLE.
- mode  input  1  0 = forward (encrypt) key order, 1 = reverse (decrypt) order. Sampled with start.
- busy  output  1  high from the cycle after an accepted start until done.
- dctr  output  1  load strobe to the decrypt stage; high for exactly 2 cycles per operation.
- rkey  output  DATAW  round key to the decrypt stage's C input; 0 when not in ROUND.
- rkey_valid  output  1  high while rkey carries a round key.
- done  output  1  single-cycle pulse after the last round key.

Behaviour:
- Reset (asynchronous, any state): state = IDLE; busy, dctr, rkey, rkey_valid, done = 0; LFSR = 5'b11111. Key buffer contents are don't-care.
- Reset wins over a simultaneous start.
- Round function: f(x) = (x & rol5(x)) ^ rol1(x), all DATAW bits wide.
- Round constant: c_i = 16'hFFFC ^ {15'b0, z_i}.
- z sequence: 5-bit LFSR, s[i+5] = s[i+2] ^ s[i], initial state all ones; z_i = s[i].
- IDLE, start = 1 (edge E0):
  - Latch kreg = k0, t0 = k1, t1 = k2, t2 = k3.
  - Latch mode.
  - Go to EXPAND with index = 0.
- EXPAND, cycles E1..E_ROUNDS, one key per cycle:
  - buf[index] <= kreg.
  - new = kreg ^ f(t0) ^ c_index.
  - Shift: kreg <= t0, t0 <= t1, t1 <= t2, t2 <= new.
  - Advance the LFSR; index++.
  - After buf[ROUNDS-1] is written, go to LOAD.
- LOAD, 2 cycles: dctr = 1, rkey = 0, rkey_valid = 0. The upstream text source presents the two cipher words during these cycles.
- ROUND, ROUNDS cycles, j = 0..ROUNDS-1:
  - rkey = buf[ROUNDS-1-j] if mode = 1, else buf[j].
  - rkey_valid = 1, dctr = 0.
- DONE, 1 cycle: done = 1; all other outputs inactive; return to IDLE.
- start in IDLE in the same cycle as DONE is not accepted. start in IDLE on the following cycle is accepted.
- Timing, all outputs registered:
  - First dctr at E(ROUNDS+1).
  - First rkey_valid at E(ROUNDS+3).
  - done at E(2*ROUNDS+3).
  - Total occupancy: 2*ROUNDS+3 cycles.
- start while busy: ignored; no effect on key, mode or sequence.
- key_in changing while busy: no effect.
- Index counter is log2(ROUNDS) bits wide. It wraps to 0 on the EXPAND→LOAD and ROUND→DONE transitions.
- Reset mid-EXPAND or mid-ROUND: immediate return to IDLE with outputs 0. A subsequent start regenerates the full sequence from key_in.

Decomposition:
- Package simeck_pkg contains: DATAW, ROUNDS, C_BASE = 16'hFFFC, LFSR_INIT = 5'b11111, the state encoding (IDLE, EXPAND, LOAD, ROUND, DONE), and function simeck_f.
- One sub-module, simeck_zlfsr: 5-bit LFSR with load-to-init and advance enable; outputs z.
- Buffer is an inferred ROUNDS x DATAW register array in the top module.

Test Plan:
- Reset: assert reset mid-idle and mid-ROUND -> busy, dctr, rkey, rkey_valid, done all 0 within the same cycle, without waiting for a clock edge.
- Forward order: key_in = 64'h1918_1110_0908_0100, mode = 0 -> rkey sequence starts 0x0100, 0x0908, 0x1110, 0x1918, 0xEDED. dctr is high exactly 2 cycles, starting 33 cycles after the start edge. done fires 67 cycles after the start edge.
- Reverse order: same key, mode = 1 -> the 32 rkey values are exactly the forward sequence reversed. The last rkey is 0x0100 and the second-to-last is 0x0908.
- System: this block driving the decrypt stage, ciphertext words 0x770d and 0x2c76 loaded during the dctr cycles, same key, mode = 1 -> after the last round the decrypt outputs are 0x6565 and 0x6877.
- start pulsed repeatedly while busy, with key_in changed -> sequence unchanged, exactly one done pulse. start in the cycle after done -> new operation accepted.
- Reset asserted at ROUND j = 10, then start with the same key -> full 32-key sequence identical to an uninterrupted run. LFSR restarts from 5'b11111.

Source files
------------

// File: rtl/simeck_pkg.sv
// Shared widths, state encoding and round function for the Simeck32/64 key scheduler.
package simeck_pkg;

  localparam int unsigned DATAW  = 16;
  localparam int unsigned ROUNDS = 32;
  localparam int unsigned KEYW   = 4 * DATAW;
  localparam int unsigned IDXW   = $clog2(ROUNDS);
  localparam int unsigned LFSRW  = 5;

  localparam logic [DATAW-1:0] C_BASE    = 16'hFFFC;
  localparam logic [LFSRW-1:0] LFSR_INIT = 5'b11111;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_EXPAND = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_ROUND  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  // Master key as presented on the bus, k0 in the LSBs.
  typedef struct packed {
    logic [DATAW-1:0] k3;
    logic [DATAW-1:0] k2;
    logic [DATAW-1:0] k1;
    logic [DATAW-1:0] k0;
  } key_t;

  // f(x) = (x & rol5(x)) ^ rol1(x)
  function automatic logic [DATAW-1:0] simeck_f(input logic [DATAW-1:0] x);
    logic [DATAW-1:0] r5;
    logic [DATAW-1:0] r1;
    r5 = {x[DATAW-6:0], x[DATAW-1:DATAW-5]};
    r1 = {x[DATAW-2:0], x[DATAW-1]};
    return (x & r5) ^ r1;
  endfunction

endpackage

// File: rtl/simeck_key_sched_if.sv
// Request/round-key bus between the key source, the scheduler and the decrypt stage.
interface simeck_key_sched_if;
  import simeck_pkg::*;

  key_t             key_in;
  logic             start;
  logic             mode;
  logic             busy;
  logic             dctr;
  logic [DATAW-1:0] rkey;
  logic             rkey_valid;
  logic             done;

  modport master (
    output key_in, start, mode,
    input  busy, dctr, rkey, rkey_valid, done
  );

  modport slave (
    input  key_in, start, mode,
    output busy, dctr, rkey, rkey_valid, done
  );

endinterface

// File: rtl/simeck_zlfsr.sv
// 5-bit Fibonacci LFSR s[i+5] = s[i+2] ^ s[i]; z is the oldest bit s[i].
module simeck_zlfsr
  import simeck_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic adv,
  output logic z
);

  logic [LFSRW-1:0] s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s <= LFSR_INIT;
    end else if (load) begin
      s <= LFSR_INIT;
    end else if (adv) begin
      s <= {s[2] ^ s[0], s[LFSRW-1:1]};
    end
  end

  assign z = s[0];

endmodule

// File: rtl/simeck_key_sched.sv
// Expands a Simeck32/64 master key into ROUNDS round keys, then plays them to the
// decrypt stage after a 2-cycle dctr load strobe, in forward or reverse order.
module simeck_key_sched
  import simeck_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  simeck_key_sched_if.slave    bus
);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [IDXW-1:0]  idx;
  logic [DATAW-1:0] kreg;
  logic [DATAW-1:0] t0;
  logic [DATAW-1:0] t1;
  logic [DATAW-1:0] t2;
  logic             mode_q;
  logic             z;
  logic             accept_c;
  logic [DATAW-1:0] new_word_c;
  logic [IDXW-1:0]  rd_idx_c;
  logic [DATAW-1:0] rk_mem [ROUNDS];

  logic             busy_q,  busy_nxt;
  logic             dctr_q,  dctr_nxt;
  logic             rkv_q,   rkv_nxt;
  logic             done_q,  done_nxt;
  logic [DATAW-1:0] rkey_q,  rkey_nxt;

  // A start coinciding with the done pulse is refused; the next cycle is accepted.
  assign accept_c   = (state == S_IDLE) && bus.start && !done_q;
  assign new_word_c = kreg ^ simeck_f(t0) ^ (C_BASE ^ {{(DATAW-1){1'b0}}, z});
  assign rd_idx_c   = mode_q ? (IDXW'(ROUNDS - 1) - idx) : idx;

  simeck_zlfsr u_zlfsr (
    .clk   (clk),
    .reset (reset),
    .load  (accept_c),
    .adv   (state == S_EXPAND),
    .z     (z)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept_c) state_nxt = S_EXPAND;
      S_EXPAND: if (idx == IDXW'(ROUNDS - 1)) state_nxt = S_LOAD;
      S_LOAD:   if (idx == IDXW'(1)) state_nxt = S_ROUND;
      S_ROUND:  if (idx == IDXW'(ROUNDS - 1)) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase

    busy_nxt = (state_nxt != S_IDLE);
    dctr_nxt = (state == S_LOAD);
    rkv_nxt  = (state == S_ROUND);
    done_nxt = (state == S_DONE);
    rkey_nxt = (state == S_ROUND) ? rk_mem[rd_idx_c] : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      dctr_q <= 1'b0;
      rkv_q  <= 1'b0;
      done_q <= 1'b0;
      rkey_q <= '0;
    end else begin
      busy_q <= busy_nxt;
      dctr_q <= dctr_nxt;
      rkv_q  <= rkv_nxt;
      done_q <= done_nxt;
      rkey_q <= rkey_nxt;
    end
  end

  // Key shift register, mode latch and shared phase index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx    <= '0;
      kreg   <= '0;
      t0     <= '0;
      t1     <= '0;
      t2     <= '0;
      mode_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept_c) begin
            kreg   <= bus.key_in.k0;
            t0     <= bus.key_in.k1;
            t1     <= bus.key_in.k2;
            t2     <= bus.key_in.k3;
            mode_q <= bus.mode;
            idx    <= '0;
          end
        end
        S_EXPAND: begin
          kreg <= t0;
          t0   <= t1;
          t1   <= t2;
          t2   <= new_word_c;
          idx  <= idx + IDXW'(1);
        end
        S_LOAD:  idx <= (idx == IDXW'(1)) ? '0 : idx + IDXW'(1);
        S_ROUND: idx <= idx + IDXW'(1);
        default: idx <= '0;
      endcase
    end
  end

  // Round-key buffer; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (state == S_EXPAND) begin
      rk_mem[idx] <= kreg;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.dctr       = dctr_q;
  assign bus.rkey       = rkey_q;
  assign bus.rkey_valid = rkv_q;
  assign bus.done       = done_q;

endmodule
